// File: rtl/rv_instruction_aligner_if.sv
// Handshake bundle between fetch, the instruction aligner and decode.
// The slave modport is the aligner's view.
interface rv_instruction_aligner_if #(
  parameter bit rv64 = 1'b0
);
  localparam int W = rv64 ? 64 : 32;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic [W-1:0] out_pc;
  logic         out_is_compressed;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;

  modport master (
    output in_valid, in_word, out_ready,
    output redirect_valid, redirect_pc,
    input  in_ready, out_valid, out_inst,
    input  out_pc, out_is_compressed
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    input  redirect_valid, redirect_pc,
    output in_ready, out_valid, out_inst,
    output out_pc, out_is_compressed
  );
endinterface

// File: rtl/rv_instruction_aligner.sv
// Fetch-side aligner: 4-halfword buffer presenting one instruction at bit 0.
// Define RV_ALIGNER_RVC_EN to enable compressed (16-bit) instructions.
module rv_instruction_aligner #(
  parameter bit          rv64     = 1'b0,
  parameter logic [63:0] reset_pc = '0
) (
  input logic clock,
  input logic reset_n,
  rv_instruction_aligner_if.slave io
);
  localparam int W = rv64 ? 64 : 32;
`ifdef RV_ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam logic [W-1:0] MASK =
    {{(W-2){1'b1}}, RVC, 1'b0};

  logic [63:0]  buf_q, buf_d;
  logic [2:0]   count_q, count_d;
  logic [W-1:0] pc_q, pc_d;
  logic         drop_q, drop_d;

  logic         head_c;
  logic         valid_c;
  logic [2:0]   cons;
  logic [2:0]   rem;
  logic [2:0]   add;
  logic         rdy;
  logic         accept;
  logic [63:0]  shifted;
  logic [63:0]  app;

  assign head_c  = RVC && (count_q != 3'd0)
                   && (buf_q[1:0] != 2'b11);
  assign valid_c = head_c || (count_q >= 3'd2);
  assign cons    = !(valid_c && io.out_ready) ? 3'd0
                 : head_c ? 3'd1 : 3'd2;
  assign rem     = count_q - cons;
  assign rdy     = !io.redirect_valid && (rem <= 3'd2);
  assign accept  = io.in_valid && rdy;
  assign shifted = buf_q >> {cons, 4'b0};
  assign app     = drop_q ? {48'h0, io.in_word[31:16]}
                          : {32'h0, io.in_word};
  assign add     = drop_q ? 3'd1 : 3'd2;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (io.redirect_valid) begin
      buf_d   = '0;
      count_d = '0;
      pc_d    = io.redirect_pc & MASK;
      drop_d  = RVC && io.redirect_pc[1];
    end else begin
      buf_d   = shifted;
      count_d = rem;
      pc_d    = pc_q + {{(W-4){1'b0}}, cons, 1'b0};
      if (accept) begin
        buf_d   = shifted | (app << {rem, 4'b0});
        count_d = rem + add;
        drop_d  = 1'b0;
      end
    end
  end

  // Halfwords beyond count are kept zero, so buf_q[31:0]
  // already reads {16'h0, h0} at count 1 and 0 when empty.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      buf_q   <= '0;
      count_q <= '0;
      pc_q    <= reset_pc[W-1:0];
      drop_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  assign io.in_ready          = rdy;
  assign io.out_valid         = valid_c;
  assign io.out_inst          = buf_q[31:0];
  assign io.out_pc            = pc_q;
  assign io.out_is_compressed = head_c;
endmodule

// File: tb/tb_rv_instruction_aligner.sv
// Self-checking bench for rv_instruction_aligner: directed scenarios
// plus a random stream against a halfword-queue reference model.
module tb_rv_instruction_aligner;
`ifdef RV_ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;

  rv_instruction_aligner_if #(.rv64(1'b0)) io();

  rv_instruction_aligner #(
    .rv64(1'b0),
    .reset_pc(64'h1000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .io(io.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
    io.in_word = '0;
    io.out_ready = 1'b0;
    io.redirect_valid = 1'b0;
    io.redirect_pc = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", io.out_valid); end
    checks++; if (io.out_pc !== 32'h1000) begin errors++; $display("FAIL reset_pc got %h exp 1000", io.out_pc); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", io.in_ready); end
    checks++; if (io.out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", io.out_inst); end
    checks++; if (io.out_is_compressed !== 1'b0) begin errors++; $display("FAIL reset_comp got %b exp 0", io.out_is_compressed); end
  endtask

  task automatic test_aligned();
    do_reset();
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_word = 32'h00A00093;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL al_rdy0 got %b exp 1", io.in_ready); end
    step();
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL al_v0 got %b exp 1", io.out_valid); end
    checks++; if (io.out_inst !== 32'h00A00093) begin errors++; $display("FAIL al_inst0 got %h exp 00a00093", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1000) begin errors++; $display("FAIL al_pc0 got %h exp 1000", io.out_pc); end
    io.in_word = 32'h00108113;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL al_rdy1 got %b exp 1", io.in_ready); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL al_v1 got %b exp 1", io.out_valid); end
    checks++; if (io.out_inst !== 32'h00108113) begin errors++; $display("FAIL al_inst1 got %h exp 00108113", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1004) begin errors++; $display("FAIL al_pc1 got %h exp 1004", io.out_pc); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL al_v2 got %b exp 0", io.out_valid); end
  endtask

  task automatic test_mixed();
    do_reset();
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_word = 32'h00934505;
    step();
    checks++; if (io.out_inst[15:0] !== 16'h4505) begin errors++; $display("FAIL mx_inst0 got %h exp 4505", io.out_inst[15:0]); end
    checks++; if (io.out_pc !== 32'h1000) begin errors++; $display("FAIL mx_pc0 got %h exp 1000", io.out_pc); end
    checks++; if (io.out_is_compressed !== 1'b1) begin errors++; $display("FAIL mx_c0 got %b exp 1", io.out_is_compressed); end
    io.in_word = 32'h000000A0;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL mx_rdy got %b exp 1", io.in_ready); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_inst !== 32'h00A00093) begin errors++; $display("FAIL mx_inst1 got %h exp 00a00093", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1002) begin errors++; $display("FAIL mx_pc1 got %h exp 1002", io.out_pc); end
    checks++; if (io.out_is_compressed !== 1'b0) begin errors++; $display("FAIL mx_c1 got %b exp 0", io.out_is_compressed); end
    step();
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL mx_v2 got %b exp 1", io.out_valid); end
    checks++; if (io.out_inst !== 32'h0) begin errors++; $display("FAIL mx_inst2 got %h exp 0", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1006) begin errors++; $display("FAIL mx_pc2 got %h exp 1006", io.out_pc); end
    checks++; if (io.out_is_compressed !== 1'b1) begin errors++; $display("FAIL mx_c2 got %b exp 1", io.out_is_compressed); end
    step();
    checks++; if (io.out_pc !== 32'h1008) begin errors++; $display("FAIL mx_pc3 got %h exp 1008", io.out_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_word = 32'h00934505;
    step();
    io.in_word = 32'h000000A0;
    step();
    io.redirect_valid = 1'b1;
    io.redirect_pc = 32'h2002;
    io.in_word = 32'hFFFFFFFF;
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL rd_rdy got %b exp 0", io.in_ready); end
    step();
    io.redirect_valid = 1'b0;
    io.in_valid = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rd_v0 got %b exp 0", io.out_valid); end
    checks++; if (io.out_pc !== 32'h2002) begin errors++; $display("FAIL rd_pc0 got %h exp 2002", io.out_pc); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rd_rdy1 got %b exp 1", io.in_ready); end
    io.in_valid = 1'b1;
    io.in_word = 32'h45011234;
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL rd_v1 got %b exp 1", io.out_valid); end
    checks++; if (io.out_inst !== 32'h00004501) begin errors++; $display("FAIL rd_inst got %h exp 00004501", io.out_inst); end
    checks++; if (io.out_pc !== 32'h2002) begin errors++; $display("FAIL rd_pc1 got %h exp 2002", io.out_pc); end
    checks++; if (io.out_is_compressed !== 1'b1) begin errors++; $display("FAIL rd_c got %b exp 1", io.out_is_compressed); end
    step();
    checks++; if (io.out_pc !== 32'h2004) begin errors++; $display("FAIL rd_pc2 got %h exp 2004", io.out_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    io.in_valid = 1'b1;
    io.in_word = 32'h00A00093;
    step();
    step();
    io.in_word = 32'hDEADBEEF;
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy0 got %b exp 0", io.in_ready); end
    step();
    checks++; if (io.out_inst !== 32'h00A00093) begin errors++; $display("FAIL bp_inst0 got %h exp 00a00093", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1000) begin errors++; $display("FAIL bp_pc0 got %h exp 1000", io.out_pc); end
    io.out_ready = 1'b1;
    io.in_word = 32'h00108113;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1 got %b exp 1", io.in_ready); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_inst !== 32'h00A00093) begin errors++; $display("FAIL bp_inst1 got %h exp 00a00093", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1004) begin errors++; $display("FAIL bp_pc1 got %h exp 1004", io.out_pc); end
    step();
    checks++; if (io.out_inst !== 32'h00108113) begin errors++; $display("FAIL bp_inst2 got %h exp 00108113", io.out_inst); end
    checks++; if (io.out_pc !== 32'h1008) begin errors++; $display("FAIL bp_pc2 got %h exp 1008", io.out_pc); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL bp_v3 got %b exp 0", io.out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    io.redirect_valid = 1'b1;
    io.redirect_pc = 32'h3002;
    step();
    io.redirect_valid = 1'b0;
    io.in_valid = 1'b1;
    io.in_word = 32'h12345678;
    step();
    step();
    reset_n = 1'b0;
    io.out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rm_v got %b exp 0", io.out_valid); end
    checks++; if (io.out_pc !== 32'h1000) begin errors++; $display("FAIL rm_pc got %h exp 1000", io.out_pc); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rm_rdy got %b exp 1", io.in_ready); end
    checks++; if (io.out_inst !== 32'h0) begin errors++; $display("FAIL rm_inst got %h exp 0", io.out_inst); end
  endtask

  task automatic test_norvc();
    do_reset();
    io.redirect_valid = 1'b1;
    io.redirect_pc = 32'h2002;
    step();
    checks++; if (io.out_pc !== 32'h2000) begin errors++; $display("FAIL nc_pc0 got %h exp 2000", io.out_pc); end
    io.redirect_pc = 32'h0;
    step();
    io.redirect_valid = 1'b0;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    io.in_word = 32'h45054505;
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL nc_v got %b exp 1", io.out_valid); end
    checks++; if (io.out_inst !== 32'h45054505) begin errors++; $display("FAIL nc_inst got %h exp 45054505", io.out_inst); end
    checks++; if (io.out_pc !== 32'h0) begin errors++; $display("FAIL nc_pc1 got %h exp 0", io.out_pc); end
    checks++; if (io.out_is_compressed !== 1'b0) begin errors++; $display("FAIL nc_c got %b exp 0", io.out_is_compressed); end
    step();
    checks++; if (io.out_pc !== 32'h4) begin errors++; $display("FAIL nc_pc2 got %h exp 4", io.out_pc); end
  endtask

  task automatic test_random();
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mdrop;
    logic [15:0] lo, hi;
    logic        ev, ec, er;
    logic [31:0] ei;
    int n, len, cons;
    do_reset();
    mpc = 32'h1000;
    mdrop = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      io.redirect_valid = ($urandom_range(0, 15) == 0);
      io.redirect_pc = $urandom;
      io.in_valid = ($urandom_range(0, 3) != 0);
      lo = $urandom;
      hi = $urandom;
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
      io.in_word = {hi, lo};
      io.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n = mq.size();
      ec = RVC && (n >= 1) && (mq[0][1:0] != 2'b11);
      len = ec ? 1 : 2;
      ev = (n >= len);
      ei = (n >= 2) ? {mq[1], mq[0]}
         : (n == 1) ? {16'h0, mq[0]} : 32'h0;
      cons = (ev && io.out_ready) ? len : 0;
      er = !io.redirect_valid && (n - cons + 2 <= 4);
      checks++; if (io.out_valid !== ev) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, io.out_valid, ev); end
      checks++; if (io.out_inst !== ei) begin errors++; $display("FAIL rnd_inst cyc %0d got %h exp %h", cyc, io.out_inst, ei); end
      checks++; if (io.out_pc !== mpc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, io.out_pc, mpc); end
      checks++; if (io.out_is_compressed !== ec) begin errors++; $display("FAIL rnd_comp cyc %0d got %b exp %b", cyc, io.out_is_compressed, ec); end
      checks++; if (io.in_ready !== er) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", cyc, io.in_ready, er); end
      if (!reset_n) begin
        mq.delete();
        mpc = 32'h1000;
        mdrop = 1'b0;
      end else if (io.redirect_valid) begin
        mq.delete();
        mpc = io.redirect_pc & (RVC ? ~32'h1 : ~32'h3);
        mdrop = RVC && io.redirect_pc[1];
      end else begin
        for (int k = 0; k < cons; k++) void'(mq.pop_front());
        mpc = mpc + 32'(2 * cons);
        if (io.in_valid && er) begin
          if (!mdrop) mq.push_back(lo);
          mq.push_back(hi);
          mdrop = 1'b0;
        end
      end
      step();
    end
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_aligned();
`ifdef RV_ALIGNER_RVC_EN
    test_mixed();
    test_redirect();
`else
    test_norvc();
`endif
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
